cond_unit: RTL and testbench
============================

# cond_unit

- Condition-check and flag-pipeline unit for the EX stage of the pipelined scalar processor.
- Consumes the scalar ALU's `{N,Z,C,V}` flag bus and evaluates the 4-bit condition field of the instruction in EX.
- Gates that instruction's register-write, memory-write and branch signals.
- Carries flag updates through two internal stages (M, W) before committing them to the architectural flag register, so flag commits stay in program order with the rest of the pipeline.

## Interface
Parameters:
- `RESET_FLAGS`, `4'b0000`: architectural `{N,Z,C,V}` value after reset.

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `valid_e`  in  1  instruction in EX is valid
- `cond_e`  in  4  condition field of EX instruction
- `flag_write_e`  in  1  EX instruction updates flags (S bit)
- `alu_flags`  in  4  `{N,Z,C,V}` from scalar ALU for EX instruction
- `reg_write_e`, `mem_write_e`, `branch_e`  in  1 each  ungated control from decode
- `stall`  in  1  freeze M, W and `flags_q`
- `flush`  in  1  kill EX instruction
- `cond_ex`  out  1  EX instruction executes
- `reg_write_ex`, `mem_write_ex`, `pc_src`  out  1 each  gated controls
- `flags_q`  out  4  architectural `{N,Z,C,V}`
- `flag_hazard`  out  1  EX instruction cannot evaluate yet

## Operation
- Condition encoding (F = effective flags):
  - 0 EQ: Z
  - 1 NE: ~Z
  - 2 CS: C
  - 3 CC: ~C
  - 4 MI: N
  - 5 PL: ~N
  - 6 VS: V
  - 7 VC: ~V
  - 8 HI: C&~Z
  - 9 LS: ~C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: ~Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F: reserved, never executes.
- `cond_ex = valid_e & ~flush & ~flag_hazard & condmet(cond_e, F)`.
- `reg_write_ex = reg_write_e & cond_ex`; `mem_write_ex = mem_write_e & cond_ex`; `pc_src = branch_e & cond_ex`.
- Flag pipe: slots M and W, each holding `{valid, flags[3:0]}`.
- When `~stall`:
  - M ← `{cond_ex & flag_write_e, alu_flags}`.
  - W ← M.
  - If W.valid, `flags_q` ← W.flags.
- A non-writing, hazarded or flushed EX instruction enters M as a bubble (valid=0).
- When `stall`: M, W and `flags_q` hold their values. Combinational outputs still track their inputs.
- Effective flags F: selected per `FLAG_FWD_EN` (see Configuration).
- `flush` never clears M or W; older flag writes always commit.
- Flag writes happen only through W.

## Timing
- Reset, sampled at a rising edge:
  - M.valid = 0, W.valid = 0, `flags_q` = `RESET_FLAGS`.
  - `flag_hazard` = 0 in the cycle after reset.
  - `cond_ex` and the gated controls are combinational: 0 whenever `valid_e` = 0.
- Reset mid-operation discards pending M/W writes; they never reach `flags_q`.
- Reset overrides `stall`.
- EX in cycle t with a flag write:
  - In M during t+1, in W during t+2.
  - Visible on `flags_q` in t+3, plus one cycle per stalled cycle.
- All outputs except `flags_q` are combinational from inputs and M/W/`flags_q` state. There is no output latency.
- Simultaneous `stall` and `flush`: registers hold; gated outputs are 0.
- Back-to-back flag writers: each commits in order. The W commit and a new M capture happen in the same edge.
- `flag_hazard` (non-forwarding build only): resolves within 2 unstalled cycles because M and W keep draining.

## Configuration
- Macro: `COND_UNIT_FLAG_FWD_EN`.
- Defined (forwarding build):
  - F = M.flags if M.valid, else W.flags if W.valid, else `flags_q`.
  - `flag_hazard` tied to 0.
- Undefined (non-forwarding build):
  - F = `flags_q`.
  - `flag_hazard = valid_e & (cond_e != 4'hE) & (M.valid | W.valid)`.
  - The hazard forces `cond_ex` = 0. The external controller must stall upstream stages but must not assert `stall` to this block.

## Test plan
- Reset with `RESET_FLAGS`=4'b0100, `valid_e`=1, `cond_e`=0 (EQ) → `flags_q`=4'b0100, `cond_ex`=1. With `cond_e`=1 (NE) → `cond_ex`=0.
- Condition sweep: force `flags_q` to each of the 16 `{N,Z,C,V}` values, apply all 16 `cond_e` with `reg_write_e`=1 → `reg_write_ex` matches the table. `cond_e`=F is always 0.
- Writer then dependent, forwarding build:
  - Cycle t: `flag_write_e`=1, `alu_flags`=4'b0100, `cond_e`=E.
  - Cycle t+1: `cond_e`=0, `branch_e`=1 → `pc_src`=1 in t+1; `flags_q`=4'b0100 in t+3.
- Same sequence, non-forwarding build:
  - `flag_hazard`=1 and `pc_src`=0 in t+1 and t+2.
  - `flag_hazard`=0 and `pc_src`=1 in t+3.
- Flush plus stall:
  - Writer with `flush`=1 → M.valid=0, and `flags_q` is unchanged after 3 cycles.
  - Writer in M, then `stall`=1 for 4 cycles → M and W hold; commit is delayed by exactly 4 cycles.
- Reset mid-operation: writer with `alu_flags`=4'b1001 in M, assert `rst` for one cycle → `flags_q`=`RESET_FLAGS`; 4'b1001 never appears on `flags_q`.

Source files
------------

// File: rtl/cond_unit.sv
// cond_unit: EX-stage condition check with a two-slot (M, W) flag pipeline
// feeding the architectural flag register. Define COND_UNIT_FLAG_FWD_EN for flag forwarding.
module cond_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_e,
  input  logic [3:0] cond_e,
  input  logic       flag_write_e,
  input  logic [3:0] alu_flags,
  input  logic       reg_write_e,
  input  logic       mem_write_e,
  input  logic       branch_e,
  input  logic       stall,
  input  logic       flush,
  output logic       cond_ex,
  output logic       reg_write_ex,
  output logic       mem_write_ex,
  output logic       pc_src,
  output logic [3:0] flags_q,
  output logic       flag_hazard
);

  typedef struct packed {
    logic       valid;
    logic [3:0] flags;
  } flag_slot_t;

  flag_slot_t m_q;
  flag_slot_t w_q;
  logic [3:0] eff_flags;

  // Conditions come in true/inverse pairs: cond[3:1] picks the base test and
  // cond[0] inverts it, so code E (always) inverts into F (never).
  function automatic logic cond_met(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    base = 1'b0;
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ cond[0];
  endfunction

`ifdef COND_UNIT_FLAG_FWD_EN
  // Youngest pending write wins, matching program order.
  always_comb begin
    eff_flags = flags_q;
    if (m_q.valid)      eff_flags = m_q.flags;
    else if (w_q.valid) eff_flags = w_q.flags;
  end

  assign flag_hazard = 1'b0;
`else
  assign eff_flags   = flags_q;
  assign flag_hazard = valid_e & (cond_e != 4'hE) & (m_q.valid | w_q.valid);
`endif

  assign cond_ex      = valid_e & ~flush & ~flag_hazard & cond_met(cond_e, eff_flags);
  assign reg_write_ex = reg_write_e & cond_ex;
  assign mem_write_ex = mem_write_e & cond_ex;
  assign pc_src       = branch_e & cond_ex;

  // NOTE: sequential state uses non-blocking assignments so W samples the old M
  // and flags_q samples the old W within the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q     <= '0;
      w_q     <= '0;
      flags_q <= RESET_FLAGS;
    end else if (!stall) begin
      m_q.valid <= cond_ex & flag_write_e;
      m_q.flags <= alu_flags;
      w_q       <= m_q;
      if (w_q.valid) flags_q <= w_q.flags;
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: the driver queues expected outputs per cycle,
// the monitor pops and compares them on the falling edge.
module tb_cond_unit;

  localparam logic [3:0] RST_FLAGS = 4'b0100;

  logic       clk = 1'b0;
  logic       rst, valid_e, flag_write_e, reg_write_e, mem_write_e, branch_e, stall, flush;
  logic [3:0] cond_e, alu_flags;
  logic       cond_ex, reg_write_ex, mem_write_ex, pc_src, flag_hazard;
  logic [3:0] flags_q;

  cond_unit #(.RESET_FLAGS(RST_FLAGS)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_e      (valid_e),
    .cond_e       (cond_e),
    .flag_write_e (flag_write_e),
    .alu_flags    (alu_flags),
    .reg_write_e  (reg_write_e),
    .mem_write_e  (mem_write_e),
    .branch_e     (branch_e),
    .stall        (stall),
    .flush        (flush),
    .cond_ex      (cond_ex),
    .reg_write_ex (reg_write_ex),
    .mem_write_ex (mem_write_ex),
    .pc_src       (pc_src),
    .flags_q      (flags_q),
    .flag_hazard  (flag_hazard)
  );

  always #5 clk = ~clk;

  typedef enum int {S_COND, S_REGW, S_MEMW, S_PC, S_FLAGS, S_HAZ} sig_e;
  typedef struct {
    string      name;
    sig_e       sig;
    logic [3:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every expectation queued for the current cycle.
  exp_t e;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sig)
        S_COND:  check(e.name, {3'b0, cond_ex}, e.val);
        S_REGW:  check(e.name, {3'b0, reg_write_ex}, e.val);
        S_MEMW:  check(e.name, {3'b0, mem_write_ex}, e.val);
        S_PC:    check(e.name, {3'b0, pc_src}, e.val);
        S_FLAGS: check(e.name, flags_q, e.val);
        default: check(e.name, {3'b0, flag_hazard}, e.val);
      endcase
    end
  end

  task automatic expect_out(input string name, input sig_e sig, input logic [3:0] val);
    exp_t x;
    x.name = name;
    x.sig  = sig;
    x.val  = val;
    sb.push_back(x);
  endtask

  task automatic idle();
    rst = 0; valid_e = 0; cond_e = 4'h0; flag_write_e = 0; alu_flags = 4'h0;
    reg_write_e = 0; mem_write_e = 0; branch_e = 0; stall = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writer(input logic [3:0] f);
    idle();
    valid_e = 1; cond_e = 4'hE; flag_write_e = 1; alu_flags = f;
  endtask

  // Reference condition table in {N,Z,C,V}
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    case (c)
      4'h0: return f[2];
      4'h1: return !f[2];
      4'h2: return f[1];
      4'h3: return !f[1];
      4'h4: return f[3];
      4'h5: return !f[3];
      4'h6: return f[0];
      4'h7: return !f[0];
      4'h8: return f[1] && !f[2];
      4'h9: return !f[1] || f[2];
      4'hA: return f[3] == f[0];
      4'hB: return f[3] != f[0];
      4'hC: return !f[2] && (f[3] == f[0]);
      4'hD: return f[2] || (f[3] != f[0]);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;

    // Reset state
    idle(); valid_e = 1; cond_e = 4'h0;
    expect_out("rst_flags", S_FLAGS, RST_FLAGS);
    expect_out("rst_eq", S_COND, 4'd1);
    expect_out("rst_haz", S_HAZ, 4'd0);
    tick();
    idle(); valid_e = 1; cond_e = 4'h1;
    expect_out("rst_ne", S_COND, 4'd0);
    tick();
    idle(); cond_e = 4'hE; reg_write_e = 1;
    expect_out("invalid_al", S_COND, 4'd0);
    expect_out("invalid_regw", S_REGW, 4'd0);
    tick();

    // Condition sweep over all flag values
    for (int v = 0; v < 16; v++) begin
      writer(v[3:0]);
      tick();
      idle(); tick();
      idle(); tick();
      for (int c = 0; c < 16; c++) begin
        idle(); valid_e = 1; cond_e = c[3:0]; reg_write_e = 1;
        if (c == 0) expect_out($sformatf("sweep_flags f=%h", v), S_FLAGS, v[3:0]);
        expect_out($sformatf("sweep f=%h c=%h", v, c), S_REGW, {3'b0, ref_cond(c[3:0], v[3:0])});
        tick();
      end
    end

    // Clear Z before the dependency test
    writer(4'b0000); tick();
    idle(); tick();
    idle(); tick();

    // Writer then dependent EQ branch
    writer(4'b0100);
    expect_out("dep_writer_cond", S_COND, 4'd1);
    tick();
    for (int k = 1; k <= 3; k++) begin
      idle(); valid_e = 1; cond_e = 4'h0; branch_e = 1;
`ifdef COND_UNIT_FLAG_FWD_EN
      expect_out($sformatf("dep_pc t+%0d", k), S_PC, 4'd1);
      expect_out($sformatf("dep_haz t+%0d", k), S_HAZ, 4'd0);
`else
      expect_out($sformatf("dep_pc t+%0d", k), S_PC, (k == 3) ? 4'd1 : 4'd0);
      expect_out($sformatf("dep_haz t+%0d", k), S_HAZ, (k == 3) ? 4'd0 : 4'd1);
`endif
      expect_out($sformatf("dep_flags t+%0d", k), S_FLAGS, (k == 3) ? 4'b0100 : 4'b0000);
      tick();
    end

    // Back-to-back writers commit in order
    writer(4'b1000); tick();
    writer(4'b0010); tick();
    idle(); valid_e = 1; cond_e = 4'h2; branch_e = 1;
`ifdef COND_UNIT_FLAG_FWD_EN
    expect_out("b2b_fwd_cs", S_PC, 4'd1);
`else
    expect_out("b2b_haz", S_HAZ, 4'd1);
    expect_out("b2b_pc", S_PC, 4'd0);
`endif
    expect_out("b2b_flags_pre", S_FLAGS, 4'b0100);
    tick();
    idle(); expect_out("b2b_first", S_FLAGS, 4'b1000); tick();
    idle(); expect_out("b2b_second", S_FLAGS, 4'b0010); tick();

    // Flushed writer never reaches the pipe
    writer(4'b0100); flush = 1; reg_write_e = 1;
    expect_out("flush_cond", S_COND, 4'd0);
    expect_out("flush_regw", S_REGW, 4'd0);
    tick();
    for (int k = 1; k <= 3; k++) begin
      idle(); valid_e = 1; cond_e = 4'h0;
      expect_out($sformatf("flush_haz %0d", k), S_HAZ, 4'd0);
      expect_out($sformatf("flush_eq %0d", k), S_COND, 4'd0);
      expect_out($sformatf("flush_flags %0d", k), S_FLAGS, 4'b0010);
      tick();
    end

    // Stall for 4 cycles with the writer in M
    writer(4'b0001); tick();
    idle(); stall = 1; valid_e = 1; cond_e = 4'hE; mem_write_e = 1;
    expect_out("stall_memw", S_MEMW, 4'd1);
    expect_out("stall_flags1", S_FLAGS, 4'b0010);
    tick();
    idle(); stall = 1; flush = 1; valid_e = 1; cond_e = 4'hE; mem_write_e = 1;
    expect_out("stall_flush_memw", S_MEMW, 4'd0);
    expect_out("stall_flush_cond", S_COND, 4'd0);
    tick();
    idle(); stall = 1; expect_out("stall_flags3", S_FLAGS, 4'b0010); tick();
    idle(); stall = 1; expect_out("stall_flags4", S_FLAGS, 4'b0010); tick();
    idle(); expect_out("stall_flags5", S_FLAGS, 4'b0010); tick();
    idle(); expect_out("stall_flags6", S_FLAGS, 4'b0010); tick();
    idle(); expect_out("stall_commit", S_FLAGS, 4'b0001); tick();

    // Reset mid-operation discards the pending write
    writer(4'b1001); tick();
    idle(); rst = 1; stall = 1;
    expect_out("midrst_pre", S_FLAGS, 4'b0001);
    tick();
    for (int k = 1; k <= 3; k++) begin
      idle(); valid_e = 1; cond_e = 4'h0;
      expect_out($sformatf("midrst_flags %0d", k), S_FLAGS, RST_FLAGS);
      expect_out($sformatf("midrst_haz %0d", k), S_HAZ, 4'd0);
      expect_out($sformatf("midrst_eq %0d", k), S_COND, 4'd1);
      tick();
    end

    idle();
    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
